uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the baud_rate_clk generator. It consumes the 16x-oversample enable from baud_rate_clk (rx_clk), recovers asynchronous serial frames from the rxd pin and presents each byte on a single-entry valid/ready output buffer. Frame-error, parity-error and overrun conditions are flagged as one-cycle pulses. It sits between the board pin and the UART host-side FIFO/controller.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the parity helper used by both directions of the link.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_TICK_W     = $clog2(DEF_OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // Expected parity bit for a payload zero-extended to 8 bits.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame recovery from rxd into a single-entry
// valid/ready buffer, with one-cycle frame, parity and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] MID_CNT  = TICK_W'((OVERSAMPLE / 32'd2) - 32'd1);
    localparam logic [TICK_W-1:0] FULL_CNT = TICK_W'(OVERSAMPLE - 32'd1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 32'd1);

    logic                 rxd_s;
    rx_state_e            state_r,    state_nxt_s;
    logic [TICK_W-1:0]    tick_cnt_r, tick_cnt_nxt_s;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r,    shift_nxt_s;
    logic                 par_bad_r,  par_bad_nxt_s;
    logic                 done_s;
    logic                 ferr_s;
    logic                 perr_s;
    logic                 exp_par_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overrun_r;

    sync_2ff #(.RST_VAL(1'b1)) u_rxd_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign exp_par_s = calc_parity(8'(shift_r), PARITY_ODD);

    // FSM, bit/tick counters and shift register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_bad_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            par_bad_r  <= par_bad_nxt_s;
        end
    end

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        par_bad_nxt_s  = par_bad_r;
        done_s         = 1'b0;
        ferr_s         = 1'b0;
        perr_s         = 1'b0;
        if (rx_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt_s    = START;
                        tick_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == MID_CNT) begin
                        tick_cnt_nxt_s = '0;
                        if (!rxd_s) begin
                            state_nxt_s   = DATA;
                            bit_cnt_nxt_s = '0;
                            par_bad_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1'b1);
                    end
                end
                DATA: begin
                    if (tick_cnt_r == FULL_CNT) begin
                        tick_cnt_nxt_s = '0;
                        shift_nxt_s    = {rxd_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_nxt_s = '0;
                            state_nxt_s   = PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1'b1);
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1'b1);
                    end
                end
                PARITY: begin
                    if (tick_cnt_r == FULL_CNT) begin
                        tick_cnt_nxt_s = '0;
                        par_bad_nxt_s  = (rxd_s != exp_par_s);
                        state_nxt_s    = STOP;
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1'b1);
                    end
                end
                STOP: begin
                    if (tick_cnt_r == FULL_CNT) begin
                        tick_cnt_nxt_s = '0;
                        if (rxd_s) begin
                            state_nxt_s = IDLE;
                            if (par_bad_r) begin
                                perr_s = 1'b1;
                            end else begin
                                done_s = 1'b1;
                            end
                        end else begin
                            ferr_s      = 1'b1;
                            state_nxt_s = WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1'b1);
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_HIGH;
                    end
                end
                default: begin
                    state_nxt_s    = IDLE;
                    tick_cnt_nxt_s = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output buffer and error pulses; the handshake runs every clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= ferr_s;
            parity_err_r <= perr_s;
            overrun_r    <= 1'b0;
            if (done_s) begin
                // A same-cycle read frees the slot for the new byte.
                if (!rx_valid_r || rx_ready) begin
                    rx_data_r  <= shift_r;
                    rx_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance driven by serial
// frames, checked against vector tables and a frame-level buffer model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick;
    logic       rxd_a, rxd_p;
    logic       ready_a, ready_p;
    logic [7:0] data_a, data_p;
    logic       valid_a, valid_p;
    logic       ferr_a, ferr_p, perr_a, perr_p, ovr_a, ovr_p;

    int tick_period = 54;
    int tick_num    = 0;
    int checks      = 0;
    int failures    = 0;
    int ferr_c [2]  = '{0, 0};
    int perr_c [2]  = '{0, 0};
    int ovr_c  [2]  = '{0, 0};
    int snap_f, snap_p, snap_o;
    int base;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par_flip;
        logic       stop_bit;
        int         low_bits;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    vec_t vecs [8];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .rx_tick(rx_tick), .rxd(rxd_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .clk(clk), .rst(rst), .rx_tick(rx_tick), .rxd(rxd_p),
        .rx_data(data_p), .rx_valid(valid_p), .rx_ready(ready_p),
        .frame_err(ferr_p), .parity_err(perr_p), .overrun(ovr_p)
    );

    always #5 clk = ~clk;

    // Oversample enable: one clock high every tick_period clocks.
    initial begin
        rx_tick = 1'b0;
        forever begin
            repeat (tick_period - 1) @(negedge clk);
            rx_tick  = 1'b1;
            tick_num = tick_num + 1;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    // Count high cycles of each pulse output; one event must equal one cycle.
    always @(posedge clk) begin
        if (ferr_a) ferr_c[0] <= ferr_c[0] + 1;
        if (ferr_p) ferr_c[1] <= ferr_c[1] + 1;
        if (perr_a) perr_c[0] <= perr_c[0] + 1;
        if (perr_p) perr_c[1] <= perr_c[1] + 1;
        if (ovr_a)  ovr_c[0]  <= ovr_c[0] + 1;
        if (ovr_p)  ovr_c[1]  <= ovr_c[1] + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_valid(input int s);
        if (s == 1) return valid_p;
        return valid_a;
    endfunction

    function automatic logic [7:0] get_data(input int s);
        if (s == 1) return data_p;
        return data_a;
    endfunction

    task automatic set_rxd(input int s, input logic v);
        if (s == 1) rxd_p = v;
        else        rxd_a = v;
    endtask

    task automatic set_ready(input int s, input logic v);
        if (s == 1) ready_p = v;
        else        ready_a = v;
    endtask

    task automatic drain(input int s);
        @(negedge clk);
        set_ready(s, 1'b1);
        @(negedge clk);
        set_ready(s, 1'b0);
    endtask

    task automatic take_snap(input int s);
        snap_f = ferr_c[s];
        snap_p = perr_c[s];
        snap_o = ovr_c[s];
    endtask

    // Returns at the negedge where a tick was just raised; b is its index.
    task automatic align_tick(output int b);
        int t0;
        t0 = tick_num;
        wait (tick_num != t0);
        b = tick_num;
    endtask

    task automatic send_frame(input int s, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit,
                              input int low_bits, input int abort_bit);
        int bc;
        bc = tick_period * 16;
        @(negedge clk);
        set_rxd(s, 1'b0);
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rxd(s, d[i]);
            if (i == abort_bit) begin
                repeat (bc / 2) @(negedge clk);
                return;
            end
            repeat (bc) @(negedge clk);
        end
        if (par_en) begin
            set_rxd(s, par_bit);
            repeat (bc) @(negedge clk);
        end
        set_rxd(s, stop_bit);
        repeat (bc) @(negedge clk);
        if (low_bits > 0) repeat (low_bits * bc) @(negedge clk);
        set_rxd(s, 1'b1);
        repeat (bc) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int s, input logic ev,
                                input logic [7:0] ed, input int ef, input int ep, input int eo);
        #1;
        check($sformatf("%s_valid", tag), get_valid(s), ev);
        if (ev) check($sformatf("%s_data", tag), get_data(s), ed);
        check($sformatf("%s_ferr", tag), ferr_c[s] - snap_f, ef);
        check($sformatf("%s_perr", tag), perr_c[s] - snap_p, ep);
        check($sformatf("%s_ovr", tag),  ovr_c[s] - snap_o, eo);
    endtask

    function automatic logic even_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    initial begin
        int         s, kind, low, ef, ep, eo;
        logic [7:0] d;
        logic       stop, flip, pb;
        logic       mv [2];
        logic [7:0] md [2];

        rst = 1'b0; rxd_a = 1'b1; rxd_p = 1'b1; ready_a = 1'b0; ready_p = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", valid_a, 1'b0);
        check("rst_data", data_a, 8'h00);
        check("rst_pulses", {ferr_a, perr_a, ovr_a, ferr_p, perr_p, ovr_p}, 6'b0);
        check("rst_valid_p", valid_p, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55 at 115200 baud; valid must rise right after the mid-stop tick.
        align_tick(base);
        take_snap(0);
        fork
            send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 0, -1);
            begin
                wait (tick_num == base + 153);
                #1 check("lat_pre", valid_a, 1'b0);
                @(negedge clk);
                #1 check("lat_post", valid_a, 1'b1);
            end
        join
        check_result("f55", 0, 1'b1, 8'h55, 0, 0, 0);
        @(negedge clk); ready_a = 1'b1;
        @(negedge clk); ready_a = 1'b0;
        #1 check("hs_clear", valid_a, 1'b0);

        tick_period = 4;

        // Short low glitch in IDLE must be rejected as a false start.
        take_snap(0);
        align_tick(base);
        @(negedge clk); rxd_a = 1'b0;
        repeat (3 * tick_period) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * 16 * tick_period) @(negedge clk);
        check_result("glitch", 0, 1'b0, 8'h00, 0, 0, 0);

        vecs[0] = '{0, 8'h3C, 1'b0, 1'b1, 0,  1'b1, 8'h3C, 0, 0};
        vecs[1] = '{1, 8'hA3, 1'b0, 1'b1, 0,  1'b1, 8'hA3, 0, 0};
        vecs[2] = '{1, 8'hA3, 1'b1, 1'b1, 0,  1'b0, 8'h00, 0, 1};
        vecs[3] = '{0, 8'h00, 1'b0, 1'b1, 0,  1'b1, 8'h00, 0, 0};
        vecs[4] = '{0, 8'hFF, 1'b0, 1'b1, 0,  1'b1, 8'hFF, 0, 0};
        vecs[5] = '{0, 8'h5A, 1'b0, 1'b0, 19, 1'b0, 8'h00, 1, 0};
        vecs[6] = '{0, 8'h81, 1'b0, 1'b1, 0,  1'b1, 8'h81, 0, 0};
        vecs[7] = '{1, 8'h00, 1'b0, 1'b1, 0,  1'b1, 8'h00, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drain(vecs[i].sel);
            take_snap(vecs[i].sel);
            pb = even_parity(vecs[i].data) ^ vecs[i].par_flip;
            align_tick(base);
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel == 1, pb,
                       vecs[i].stop_bit, vecs[i].low_bits, -1);
            check_result($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp_valid,
                         vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr, 0);
        end

        // Overrun: second byte dropped while the first is unread.
        drain(0);
        take_snap(0);
        align_tick(base);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 0, -1);
        check_result("ovr_first", 0, 1'b1, 8'h11, 0, 0, 0);
        take_snap(0);
        align_tick(base);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 0, -1);
        check_result("ovr_second", 0, 1'b1, 8'h11, 0, 0, 1);
        // Read in the completion cycle: new byte replaces the old one.
        take_snap(0);
        align_tick(base);
        fork
            send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 0, -1);
            begin
                wait (tick_num == base + 153);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        check_result("ovr_same", 0, 1'b1, 8'h22, 0, 0, 0);

        // Reset during data bit 4 clears outputs immediately.
        align_tick(base);
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 0, 4);
        rst = 1'b0;
        #1;
        check("mrst_valid", valid_a, 1'b0);
        check("mrst_data", data_a, 8'h00);
        check("mrst_valid_p", valid_p, 1'b0);
        check("mrst_pulses", {ferr_a, perr_a, ovr_a}, 3'b0);
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * 16 * tick_period) @(negedge clk);
        #1 check("mrst_noframe", valid_a, 1'b0);
        take_snap(0);
        align_tick(base);
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 0, -1);
        check_result("mrst_f0", 0, 1'b1, 8'hF0, 0, 0, 0);

        // Random frames against a frame-level model of the output buffer.
        drain(0);
        drain(1);
        mv[0] = 1'b0; mv[1] = 1'b0; md[0] = 8'h00; md[1] = 8'h00;
        for (int k = 0; k < 16; k++) begin
            s    = $urandom_range(0, 1);
            d    = 8'($urandom);
            kind = $urandom_range(0, 7);
            stop = 1'b1; flip = 1'b0; low = 0;
            if (kind == 0) begin
                stop = 1'b0;
                low  = 1;
            end else if (kind == 1 && s == 1) begin
                flip = 1'b1;
            end
            ef = 0; ep = 0; eo = 0;
            if (!stop)           ef = 1;
            else if (flip)       ep = 1;
            else if (mv[s])      eo = 1;
            else begin
                mv[s] = 1'b1;
                md[s] = d;
            end
            take_snap(s);
            align_tick(base);
            send_frame(s, d, s == 1, even_parity(d) ^ flip, stop, low, -1);
            check_result($sformatf("rnd%0d", k), s, mv[s], md[s], ef, ep, eo);
            if ($urandom_range(0, 1) == 1) begin
                drain(s);
                mv[s] = 1'b0;
                #1 check($sformatf("rnd%0d_read", k), get_valid(s), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
